// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: registered program counter with four next-PC sources, halt/fault trapping and debug counters.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 240,
    parameter logic [5:0]  HALT_OP   = 6'b111111
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [5:0]  Op_code,
    input  logic [15:0] Imm_number,
    input  logic [25:0] Jump_target,
    input  logic [31:0] Rs_data,
    output logic [31:0] IAddr,
    output logic [31:0] PC4,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] Fault_addr,
    output logic [31:0] Inst_count,
    output logic [31:0] Cycle_count
);
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

    state_t      state, state_n;
    logic [31:0] npc, iaddr_n, fault_addr_n, inst_n, cycle_n;
    logic        legal;

    assign PC4 = IAddr + 32'd4;

    always_comb begin
        npc = PCSrc == 2'b00 ? PC4 :
              PCSrc == 2'b01 ? PC4 + {{14{Imm_number[15]}}, Imm_number, 2'b00} :
              PCSrc == 2'b10 ? {PC4[31:28], Jump_target, 2'b00} : Rs_data;
        // 33-bit compare so an address near 2^32 cannot wrap into range
        legal = npc[1:0] == 2'b00 && ({1'b0, npc} + 33'd3) < 33'(MEM_BYTES);
    end

    always_comb begin
        state_n      = state;
        iaddr_n      = IAddr;
        fault_addr_n = Fault_addr;
        inst_n       = Inst_count;
        cycle_n      = Cycle_count;
        if (state == RUN) begin
            cycle_n = &Cycle_count ? Cycle_count : Cycle_count + 32'd1;
            if (!Stall) begin
                if (Op_code == HALT_OP) begin
                    state_n = HALT;
                end else if (!legal) begin
                    state_n      = FAULT;
                    fault_addr_n = npc;
                end else begin
                    iaddr_n = npc;
                    inst_n  = Inst_count + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= RUN;
            IAddr       <= RESET_PC;
            Fault_addr  <= '0;
            Inst_count  <= '0;
            Cycle_count <= '0;
        end else begin
            state       <= state_n;
            IAddr       <= iaddr_n;
            Fault_addr  <= fault_addr_n;
            Inst_count  <= inst_n;
            Cycle_count <= cycle_n;
        end
    end

    assign Halted = state == HALT;
    assign Fault  = state == FAULT;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plan plus random stimulus checked against an arithmetic reference model.
module tb_pc_fetch_unit;
    logic        CLK = 0, Reset, Stall;
    logic [1:0]  PCSrc;
    logic [5:0]  Op_code;
    logic [15:0] Imm_number;
    logic [25:0] Jump_target;
    logic [31:0] Rs_data;
    logic [31:0] IAddr, PC4, Fault_addr, Inst_count, Cycle_count;
    logic        Halted, Fault;

    int checks = 0, failures = 0;

    // reference model: 0 running, 1 halted, 2 faulted
    int          m_st;
    logic [31:0] m_pc, m_faddr, m_inst, m_cyc;

    pc_fetch_unit dut (
        .CLK(CLK), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc), .Op_code(Op_code),
        .Imm_number(Imm_number), .Jump_target(Jump_target), .Rs_data(Rs_data),
        .IAddr(IAddr), .PC4(PC4), .Halted(Halted), .Fault(Fault), .Fault_addr(Fault_addr),
        .Inst_count(Inst_count), .Cycle_count(Cycle_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] n;
        longint      target;
        if (Reset) begin
            m_st = 0; m_pc = 0; m_faddr = 0; m_inst = 0; m_cyc = 0;
        end else if (m_st == 0) begin
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (!Stall) begin
                case (PCSrc)
                    2'd0: n = m_pc + 4;
                    2'd1: n = m_pc + 4 + 32'($signed(Imm_number) * 4);
                    2'd2: n = ((m_pc + 4) & 32'hF000_0000) | (32'(Jump_target) * 4);
                    default: n = Rs_data;
                endcase
                target = longint'(n) + 3;
                if (Op_code == 6'b111111) m_st = 1;
                else if (n % 4 == 0 && target < 240) begin
                    m_pc = n; m_inst = m_inst + 1;
                end else begin
                    m_st = 2; m_faddr = n;
                end
            end
        end
    endtask

    task automatic tick(input logic rst, input logic stl, input logic [1:0] src, input logic [5:0] op,
                        input logic [15:0] imm, input logic [25:0] jt, input logic [31:0] rs);
        @(negedge CLK);
        Reset = rst; Stall = stl; PCSrc = src; Op_code = op;
        Imm_number = imm; Jump_target = jt; Rs_data = rs;
        @(posedge CLK);
        model_edge();
        #1;
        chk("IAddr", IAddr, m_pc);
        chk("PC4", PC4, m_pc + 4);
        chk("Halted", 32'(Halted), 32'(m_st == 1));
        chk("Fault", 32'(Fault), 32'(m_st == 2));
        chk("Fault_addr", Fault_addr, m_faddr);
        chk("Inst_count", Inst_count, m_inst);
        chk("Cycle_count", Cycle_count, m_cyc);
    endtask

    initial begin
        logic [31:0] cyc_snap;
        m_st = 0; m_pc = 0; m_faddr = 0; m_inst = 0; m_cyc = 0;
        tick(1, 0, 0, 0, 0, 0, 0);
        chk("reset_iaddr", IAddr, 32'd0);
        chk("reset_cycles", Cycle_count, 32'd0);
        repeat (5) tick(0, 0, 0, 0, 0, 0, 0);
        chk("seq_iaddr", IAddr, 32'd20);
        chk("seq_inst", Inst_count, 32'd5);
        chk("seq_cycles", Cycle_count, 32'd5);
        tick(0, 0, 3, 0, 0, 0, 32'd8);
        tick(0, 0, 1, 0, 16'hFFFE, 0, 0);
        chk("branch_back", IAddr, 32'd4);
        tick(0, 0, 1, 0, 16'h0003, 0, 0);
        chk("branch_fwd", IAddr, 32'd20);
        tick(0, 0, 3, 0, 0, 0, 32'd16);
        tick(0, 0, 2, 0, 0, 26'h000000A, 0);
        chk("jump", IAddr, 32'd40);
        tick(0, 0, 3, 0, 0, 0, 32'd2);
        chk("misalign_fault", 32'(Fault), 32'd1);
        chk("misalign_addr", Fault_addr, 32'd2);
        chk("misalign_hold", IAddr, 32'd40);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("fault_frozen", IAddr, 32'd40);
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 3, 0, 0, 0, 32'd232);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("last_word", IAddr, 32'd236);
        chk("last_word_nofault", 32'(Fault), 32'd0);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("range_fault", 32'(Fault), 32'd1);
        chk("range_addr", Fault_addr, 32'd240);
        tick(0, 0, 3, 0, 0, 0, 32'hFFFF_FFFC);
        tick(1, 0, 0, 0, 0, 0, 0);
        chk("post_reset_iaddr", IAddr, 32'd0);
        chk("post_reset_fault", 32'(Fault), 32'd0);
        chk("post_reset_inst", Inst_count, 32'd0);
        tick(0, 0, 3, 0, 0, 0, 32'hFFFF_FFFC);
        chk("wrap_fault", 32'(Fault), 32'd1);
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 3, 0, 0, 0, 32'd12);
        repeat (3) tick(0, 1, 0, 0, 0, 0, 0);
        chk("stall_iaddr", IAddr, 32'd12);
        chk("stall_inst", Inst_count, 32'd1);
        chk("stall_cycles", Cycle_count, 32'd4);
        tick(0, 1, 0, 6'b111111, 0, 0, 0);
        chk("stall_no_halt", 32'(Halted), 32'd0);
        tick(0, 0, 3, 0, 0, 0, 32'd12);
        chk("self_loop_iaddr", IAddr, 32'd12);
        chk("self_loop_inst", Inst_count, 32'd2);
        tick(0, 0, 3, 0, 0, 0, 32'd24);
        tick(0, 0, 0, 6'b111111, 0, 0, 0);
        chk("halt", 32'(Halted), 32'd1);
        chk("halt_iaddr", IAddr, 32'd24);
        cyc_snap = Cycle_count;
        tick(0, 0, 3, 0, 0, 0, 32'd100);
        tick(0, 1, 2, 0, 0, 26'h1, 0);
        chk("halt_frozen_iaddr", IAddr, 32'd24);
        chk("halt_frozen_cycles", Cycle_count, cyc_snap);
        tick(1, 0, 0, 0, 0, 0, 0);
        chk("halt_reset", 32'(Halted), 32'd0);
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 3, 0, 0, 0, 32'd236);
        tick(0, 0, 0, 6'b111111, 0, 0, 0);
        chk("halt_beats_fault", 32'(Halted), 32'd1);
        chk("halt_beats_fault_f", 32'(Fault), 32'd0);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rs;
            rs = $urandom_range(0, 15) == 0 ? $urandom : 32'($urandom_range(0, 62)) * 4;
            tick($urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0, 2'($urandom),
                 $urandom_range(0, 30) == 0 ? 6'b111111 : 6'($urandom_range(0, 62)),
                 16'($signed($urandom_range(0, 12)) - 6), 26'($urandom_range(0, 64)), rs);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
